player_hit_judge: RTL and testbench

Downstream consumer of the enemy-bullet stage in the VGA shooter. Once per video frame it checks the enemy bullet's rectangle against the player plane's rectangle and manages player lives and a post-hit invulnerability/blink window. It flags game-over. It emits a single-cycle `hit` pulse back to the bullet stage so the bullet respawns at the enemy.

---
 rtl/player_hit_judge_pkg.sv | 14 +
 rtl/rect_overlap.sv | 30 +++
 rtl/player_hit_judge.sv | 142 ++++++++++++++
 tb/tb_player_hit_judge.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/player_hit_judge_pkg.sv
// Shared game constants and the player hit-judge state encoding.
package player_hit_judge_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic [1:0] {
        PLAY,
        INVULN,
        OVER
    } hit_state_t;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle overlap test; sums carry one extra bit
// so a rectangle near the right/bottom edge of the coordinate range never wraps.
module rect_overlap
    import player_hit_judge_pkg::*;
#(
    parameter int unsigned AW = 46,
    parameter int unsigned AH = 40,
    parameter int unsigned BW = 4,
    parameter int unsigned BH = 40
) (
    input  logic [COORD_W-1:0] a_x_i,
    input  logic [COORD_W-1:0] a_y_i,
    input  logic [COORD_W-1:0] b_x_i,
    input  logic [COORD_W-1:0] b_y_i,
    output logic               overlap_o
);

    localparam int unsigned SW = COORD_W + 1;

    logic [SW-1:0] ax, ay, bx, by;

    assign ax = {1'b0, a_x_i};
    assign ay = {1'b0, a_y_i};
    assign bx = {1'b0, b_x_i};
    assign by = {1'b0, b_y_i};

    assign overlap_o = (bx < ax + SW'(AW)) && (ax < bx + SW'(BW)) &&
                       (by < ay + SW'(AH)) && (ay < by + SW'(BH));

endmodule

// File: rtl/player_hit_judge.sv
// Per-frame enemy-bullet vs player judge: lives, post-hit invulnerability with
// blinking sprite, and game-over. All outputs come straight from flops.
module player_hit_judge
    import player_hit_judge_pkg::*;
#(
    parameter int unsigned PW         = 46,
    parameter int unsigned PH         = 40,
    parameter int unsigned BW         = 4,
    parameter int unsigned BH         = 40,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned INV_FRAMES = 120,
    parameter int unsigned BLINK_DIV  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               restart,
    input  logic               eb_valid,
    input  logic [COORD_W-1:0] eb_x,
    input  logic [COORD_W-1:0] eb_y,
    input  logic [COORD_W-1:0] pp_x,
    input  logic [COORD_W-1:0] pp_y,
    output logic               hit,
    output logic [1:0]         lives,
    output logic               player_visible,
    output logic               game_over,
    output logic               boom
);

    localparam int unsigned CNT_W = $clog2(INV_FRAMES + 1);

    hit_state_t       state_q, state_d;
    logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
    logic [1:0]       lives_q, lives_d;
    logic             hit_q, hit_d;
    logic             vis_q, vis_d;
    logic             over_q, over_d;

    logic             rect_hit;
    logic             ovl;
    logic [CNT_W-1:0] elapsed;
    logic             blink_tog;

    rect_overlap #(
        .AW(PW),
        .AH(PH),
        .BW(BW),
        .BH(BH)
    ) u_overlap (
        .a_x_i    (pp_x),
        .a_y_i    (pp_y),
        .b_x_i    (eb_x),
        .b_y_i    (eb_y),
        .overlap_o(rect_hit)
    );

    assign ovl       = eb_valid && rect_hit;
    // Blink phase is measured from the hit tick using the pre-decrement count.
    assign elapsed   = CNT_W'(INV_FRAMES) - inv_cnt_q;
    assign blink_tog = (32'(elapsed) % BLINK_DIV) == (BLINK_DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PLAY;
            inv_cnt_q <= '0;
            lives_q   <= 2'(LIVES);
            hit_q     <= 1'b0;
            vis_q     <= 1'b1;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            inv_cnt_q <= inv_cnt_d;
            lives_q   <= lives_d;
            hit_q     <= hit_d;
            vis_q     <= vis_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = PLAY;
        end else begin
            case (state_q)
                PLAY:    if (frame_tick && ovl) state_d = (lives_q <= 2'd1) ? OVER : INVULN;
                INVULN:  if (frame_tick && inv_cnt_q <= CNT_W'(1)) state_d = PLAY;
                OVER:    state_d = OVER;
                default: state_d = PLAY;
            endcase
        end
    end

    always_comb begin
        hit_d     = 1'b0;
        lives_d   = lives_q;
        inv_cnt_d = inv_cnt_q;
        vis_d     = vis_q;
        if (restart) begin
            lives_d   = 2'(LIVES);
            inv_cnt_d = '0;
            vis_d     = 1'b1;
        end else begin
            case (state_q)
                PLAY: begin
                    vis_d = 1'b1;
                    if (frame_tick && ovl) begin
                        hit_d = 1'b1;
                        vis_d = 1'b0;
                        if (lives_q <= 2'd1) begin
                            lives_d = 2'd0;
                        end else begin
                            lives_d   = lives_q - 2'd1;
                            inv_cnt_d = CNT_W'(INV_FRAMES);
                        end
                    end
                end
                INVULN: begin
                    if (frame_tick) begin
                        if (inv_cnt_q <= CNT_W'(1)) begin
                            inv_cnt_d = '0;
                            vis_d     = 1'b1;
                        end else begin
                            inv_cnt_d = inv_cnt_q - CNT_W'(1);
                            if (blink_tog) vis_d = ~vis_q;
                        end
                    end
                end
                OVER:    vis_d = 1'b0;
                default: vis_d = 1'b1;
            endcase
        end
        over_d = (state_d == OVER);
    end

    assign hit            = hit_q;
    assign lives          = lives_q;
    assign player_visible = vis_q;
    assign game_over      = over_q;
    assign boom           = over_q;

endmodule

// File: tb/tb_player_hit_judge.sv
// Scoreboard bench for player_hit_judge: directed tick vectors queue their
// expected outputs; a monitor pops and compares after each tick/restart edge.
module tb_player_hit_judge;

    import player_hit_judge_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       restart;
    logic       eb_valid;
    logic [9:0] eb_x, eb_y, pp_x, pp_y;
    logic       hit;
    logic [1:0] lives;
    logic       player_visible;
    logic       game_over;
    logic       boom;

    typedef struct packed {
        logic       hit;
        logic [1:0] lives;
        logic       vis;
        logic       go;
        logic       boom;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned vec_idx = 0;

    player_hit_judge #(
        .PW(46), .PH(40), .BW(4), .BH(40),
        .LIVES(3), .INV_FRAMES(120), .BLINK_DIV(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .restart       (restart),
        .eb_valid      (eb_valid),
        .eb_x          (eb_x),
        .eb_y          (eb_y),
        .pp_x          (pp_x),
        .pp_y          (pp_y),
        .hit           (hit),
        .lives         (lives),
        .player_visible(player_visible),
        .game_over     (game_over),
        .boom          (boom)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic h, input logic [1:0] l, input logic v,
                                input logic g, input logic b);
        exp_t e;
        e.hit = h; e.lives = l; e.vis = v; e.go = g; e.boom = b;
        return e;
    endfunction

    function automatic exp_t dut_out();
        return mk(hit, lives, player_visible, game_over, boom);
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got hit=%0b lives=%0d vis=%0b go=%0b boom=%0b, want hit=%0b lives=%0d vis=%0b go=%0b boom=%0b",
                     name, act.hit, act.lives, act.vis, act.go, act.boom,
                     want.hit, want.lives, want.vis, want.go, want.boom);
        end
    endtask

    // Monitor: an edge that saw frame_tick or restart owes one scoreboard entry;
    // every other edge must leave hit low.
    initial begin
        logic ev;
        forever begin
            @(posedge clk);
            ev = frame_tick | restart;
            @(negedge clk);
            if (ev) begin
                vec_idx++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL vec%0d: DUT event with empty scoreboard", vec_idx);
                end else begin
                    check($sformatf("vec%0d", vec_idx), dut_out(), exp_q.pop_front());
                end
            end else begin
                n_cmp++;
                if (hit !== 1'b0) begin
                    n_err++;
                    $display("FAIL hit_idle: got hit=%0b, want 0", hit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input logic [9:0] ex, input logic [9:0] ey, input logic [9:0] px,
                        input logic [9:0] py, input logic v, input logic rs, input exp_t e);
        eb_x = ex; eb_y = ey; pp_x = px; pp_y = py; eb_valid = v;
        frame_tick = 1'b1;
        restart    = rs;
        exp_q.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        restart    = 1'b0;
        @(negedge clk);
    endtask

    task automatic ovl_tick(input exp_t e);
        tick(10'd100, 10'd200, 10'd90, 10'd190, 1'b1, 1'b0, e);
    endtask

    task automatic restart_only(input exp_t e);
        restart = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; restart = 1'b0; eb_valid = 1'b0;
        eb_x = '0; eb_y = '0; pp_x = '0; pp_y = '0;
        repeat (2) @(negedge clk);
        check("reset", dut_out(), mk(1'b0, 2'd3, 1'b1, 1'b0, 1'b0));
        rst = 1'b0;
        @(negedge clk);

        // Right edge adjacency: 136 = 90+46 touches but does not overlap.
        tick(10'd136, 10'd200, 10'd90, 10'd190, 1'b1, 1'b0, mk(1'b0, 2'd3, 1'b1, 1'b0, 1'b0));
        // pp_x+PW = 1046 must not wrap to 22 and falsely pass.
        tick(10'd20, 10'd200, 10'd1000, 10'd190, 1'b1, 1'b0, mk(1'b0, 2'd3, 1'b1, 1'b0, 1'b0));
        tick(10'd100, 10'd200, 10'd90, 10'd190, 1'b0, 1'b0, mk(1'b0, 2'd3, 1'b1, 1'b0, 1'b0));
        tick(10'd135, 10'd200, 10'd90, 10'd190, 1'b1, 1'b0, mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0));

        // Invulnerable window: visibility flips after every 8th tick, back on at tick 120.
        for (int k = 1; k <= 120; k++)
            ovl_tick(mk(1'b0, 2'd2, (k == 120) ? 1'b1 : 1'(((k / 8) % 2)), 1'b0, 1'b0));
        ovl_tick(mk(1'b1, 2'd1, 1'b0, 1'b0, 1'b0));

        for (int k = 1; k <= 120; k++)
            ovl_tick(mk(1'b0, 2'd1, (k == 120) ? 1'b1 : 1'(((k / 8) % 2)), 1'b0, 1'b0));
        ovl_tick(mk(1'b1, 2'd0, 1'b0, 1'b1, 1'b1));
        repeat (2) ovl_tick(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1));

        restart_only(mk(1'b0, 2'd3, 1'b1, 1'b0, 1'b0));
        tick(10'd100, 10'd200, 10'd90, 10'd190, 1'b1, 1'b1, mk(1'b0, 2'd3, 1'b1, 1'b0, 1'b0));
        ovl_tick(mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 5; k++)
            ovl_tick(mk(1'b0, 2'd2, 1'b0, 1'b0, 1'b0));

        // Asynchronous reset mid-invulnerability, sampled before any clock edge.
        #1 rst = 1'b1;
        #1 check("async_rst", dut_out(), mk(1'b0, 2'd3, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ovl_tick(mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d scoreboard entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
